// File: rtl/phase_sequencer.sv
// phase_sequencer: IF/DE/EX/WB phase generator with run/stop/single-step
// panel control, a PC breakpoint, a memory wait-stall and a counter of
// retired instructions. Its only job is to drive the one-hot phase the
// controller decodes; it touches no datapath signal.
module phase_sequencer #(
  parameter logic RESET_STEP = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        step,
  input  logic        mem_wait,
  input  logic [31:0] pc,
  input  logic        break_en,
  input  logic [31:0] break_addr,
  input  logic        cnt_clr,
  output logic [3:0]  cstate,
  output logic        running,
  output logic        halted,
  output logic        bp_hit,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_HALT = 3'd0,
    S_IF   = 3'd1,
    S_DE   = 3'd2,
    S_EX   = 3'd3,
    S_WB   = 3'd4
  } state_t;

  typedef enum logic {
    M_RUN  = 1'b0,
    M_STEP = 1'b1
  } mode_t;

  localparam mode_t RESET_MODE = RESET_STEP ? M_STEP : M_RUN;

  state_t      state, state_n;
  mode_t       mode, mode_n;
  logic        stop_pend, stop_pend_n;
  logic        start_q, stop_q, step_q;
  logic        bp_hit_n;
  logic [31:0] count_n;

  logic start_edge, stop_edge, step_edge;
  logic wb_done;

  assign start_edge = start & ~start_q;
  assign stop_edge  = stop  & ~stop_q;
  assign step_edge  = step  & ~step_q;

  // WB completes only on an edge where memory is ready.
  assign wb_done = (state == S_WB) && !mem_wait;

  // State, mode, pending-stop, edge-detect and counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_HALT;
      mode        <= RESET_MODE;
      stop_pend   <= 1'b0;
      start_q     <= 1'b0;
      stop_q      <= 1'b0;
      step_q      <= 1'b0;
      bp_hit      <= 1'b0;
      instr_count <= '0;
    end else begin
      state       <= state_n;
      mode        <= mode_n;
      stop_pend   <= stop_pend_n;
      start_q     <= start;
      stop_q      <= stop;
      step_q      <= step;
      bp_hit      <= bp_hit_n;
      instr_count <= count_n;
    end
  end

  // Next-state logic: phase sequencing, panel requests, completion decisions.
  always_comb begin
    state_n     = state;
    mode_n      = mode;
    stop_pend_n = stop_pend;
    bp_hit_n    = 1'b0;
    count_n     = instr_count;

    if (stop_edge && (state != S_HALT)) begin
      stop_pend_n = 1'b1;
    end

    unique case (state)
      S_HALT: begin
        if (step_edge) begin
          mode_n  = M_STEP;
          state_n = S_IF;
        end else if (start_edge) begin
          mode_n  = M_RUN;
          state_n = S_IF;
        end
      end
      S_IF: begin
        if (!mem_wait) begin
          state_n = S_DE;
        end
      end
      S_DE: state_n = S_EX;
      S_EX: state_n = S_WB;
      S_WB: begin
        if (!mem_wait) begin
          count_n = instr_count + 32'd1;
          if (mode == M_STEP) begin
            state_n = S_HALT;
          end else if (stop_pend) begin
            state_n = S_HALT;
          end else if (break_en && (pc == break_addr)) begin
            state_n  = S_HALT;
            bp_hit_n = 1'b1;
          end else begin
            state_n = S_IF;
          end
          // A pending stop is consumed by any return to HALT so it cannot
          // leak into the next run.
          if (state_n == S_HALT) begin
            stop_pend_n = 1'b0;
          end
        end
      end
      default: state_n = S_HALT;
    endcase

    if (cnt_clr) begin
      count_n = '0;
    end
  end

  // Phase decode; IF and WB are blanked while memory is stalling.
  always_comb begin
    cstate = '0;
    unique case (state)
      S_IF:    cstate = mem_wait ? 4'b0000 : 4'b0001;
      S_DE:    cstate = 4'b0010;
      S_EX:    cstate = 4'b0100;
      S_WB:    cstate = mem_wait ? 4'b0000 : 4'b1000;
      default: cstate = '0;
    endcase
  end

  assign halted  = (state == S_HALT);
  assign running = (mode == M_RUN) && !halted;

  // wb_done is folded into count_n; keep it visible for clarity of intent.
  logic unused_wb_done;
  assign unused_wb_done = wb_done;

endmodule

// File: tb/tb_phase_sequencer.sv
// Directed-vector bench for phase_sequencer. The driver issues one row of
// inputs per cycle and queues the hand-computed outputs for that cycle; a
// monitor pops and compares them mid-cycle.
module tb_phase_sequencer;

  logic        clock;
  logic        reset;
  logic        start, stop, step, mem_wait;
  logic [31:0] pc;
  logic        break_en;
  logic [31:0] break_addr;
  logic        cnt_clr;
  logic [3:0]  cstate;
  logic        running, halted, bp_hit;
  logic [31:0] instr_count;

  localparam logic [3:0] C0 = 4'b0000;
  localparam logic [3:0] CI = 4'b0001;
  localparam logic [3:0] CD = 4'b0010;
  localparam logic [3:0] CE = 4'b0100;
  localparam logic [3:0] CW = 4'b1000;

  typedef struct packed {
    logic [3:0]  cs;
    logic        h;
    logic        r;
    logic        bp;
    logic [31:0] cnt;
    logic [15:0] row;
  } exp_t;

  exp_t exp_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   row_no = 0;

  phase_sequencer #(.RESET_STEP(1'b0)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .step        (step),
    .mem_wait    (mem_wait),
    .pc          (pc),
    .break_en    (break_en),
    .break_addr  (break_addr),
    .cnt_clr     (cnt_clr),
    .cstate      (cstate),
    .running     (running),
    .halted      (halted),
    .bp_hit      (bp_hit),
    .instr_count (instr_count)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Monitor: compare the queued expectation against the DUT mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests_run++;
      if (cstate !== e.cs || halted !== e.h || running !== e.r ||
          bp_hit !== e.bp || instr_count !== e.cnt) begin
        tests_failed++;
        $display("FAIL row%0d: got cstate=%b halted=%b running=%b bp_hit=%b count=%0d, expected cstate=%b halted=%b running=%b bp_hit=%b count=%0d",
                 e.row, cstate, halted, running, bp_hit, instr_count,
                 e.cs, e.h, e.r, e.bp, e.cnt);
      end
    end
  end

  // One cycle: drive inputs just after the rising edge, queue expected outputs.
  task automatic cyc(input logic r, input logic st, input logic sp,
                     input logic stp, input logic mw, input logic [31:0] p,
                     input logic clr, input logic [3:0] ecs, input logic eh,
                     input logic er, input logic ebp, input logic [31:0] ecnt);
    exp_t e;
    @(posedge clock);
    #1;
    reset    = r;
    start    = st;
    stop     = sp;
    step     = stp;
    mem_wait = mw;
    pc       = p;
    cnt_clr  = clr;
    e.cs  = ecs;
    e.h   = eh;
    e.r   = er;
    e.bp  = ebp;
    e.cnt = ecnt;
    e.row = row_no[15:0];
    exp_q.push_back(e);
    row_no++;
  endtask

  // Four unstalled phases; stop_ph selects a phase (0..3) that pulses stop.
  task automatic instr4(input logic er, input logic [31:0] cnt,
                        input logic [31:0] pa, input logic [31:0] pn,
                        input int unsigned stop_ph);
    cyc(1, 0, stop_ph == 0, 0, 0, pa, 0, CI, 0, er, 0, cnt);
    cyc(1, 0, stop_ph == 1, 0, 0, pa, 0, CD, 0, er, 0, cnt);
    cyc(1, 0, stop_ph == 2, 0, 0, pa, 0, CE, 0, er, 0, cnt);
    cyc(1, 0, stop_ph == 3, 0, 0, pn, 0, CW, 0, er, 0, cnt);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; stop = 1'b0; step = 1'b0; mem_wait = 1'b0;
    pc = '0; break_en = 1'b0; break_addr = 32'h0000_0010; cnt_clr = 1'b0;

    // Reset then free run from a start pulse.
    cyc(0, 0, 0, 0, 0, 0, 0, C0, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0, 0, 0, C0, 1, 0, 0, 0);
    instr4(1, 0, 0, 0, 4);
    instr4(1, 1, 0, 0, 4);
    instr4(1, 2, 0, 0, 4);
    instr4(1, 3, 0, 0, 4);
    // Stop during DE of instruction 5: it still completes.
    instr4(1, 4, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, C0, 1, 0, 0, 5);
    cyc(1, 0, 1, 0, 0, 0, 0, C0, 1, 0, 0, 5);
    cyc(1, 0, 0, 0, 0, 0, 0, C0, 1, 0, 0, 5);

    // Single step, twice, then start+step together.
    cyc(1, 0, 0, 1, 0, 0, 0, C0, 1, 0, 0, 5);
    instr4(0, 5, 0, 0, 4);
    cyc(1, 0, 0, 0, 0, 0, 0, C0, 1, 0, 0, 6);
    cyc(1, 0, 0, 1, 0, 0, 0, C0, 1, 0, 0, 6);
    instr4(0, 6, 0, 0, 4);
    cyc(1, 0, 0, 0, 0, 0, 0, C0, 1, 0, 0, 7);
    cyc(1, 1, 0, 1, 0, 0, 0, C0, 1, 0, 0, 7);
    instr4(0, 7, 0, 0, 4);
    cyc(1, 0, 0, 0, 0, 0, 0, C0, 1, 0, 0, 8);
    cyc(1, 0, 0, 0, 0, 0, 1, C0, 1, 0, 0, 8);

    // Breakpoint at 0x10, then restart through it.
    break_en = 1'b1;
    cyc(1, 1, 0, 0, 0, 32'h0, 0, C0, 1, 0, 0, 0);
    instr4(1, 0, 32'h0, 32'h4, 4);
    instr4(1, 1, 32'h4, 32'h8, 4);
    instr4(1, 2, 32'h8, 32'hC, 4);
    instr4(1, 3, 32'hC, 32'h10, 4);
    cyc(1, 0, 0, 0, 0, 32'h10, 0, C0, 1, 0, 1, 4);
    cyc(1, 1, 0, 0, 0, 32'h10, 0, C0, 1, 0, 0, 4);
    instr4(1, 4, 32'h10, 32'h14, 2);
    cyc(1, 0, 0, 0, 0, 32'h14, 0, C0, 1, 0, 0, 5);
    break_en = 1'b0;

    // Memory stall: 3 cycles at IF, 2 at WB; stop queued during the WB stall.
    cyc(1, 1, 0, 0, 0, 0, 0, C0, 1, 0, 0, 5);
    cyc(1, 0, 0, 0, 1, 0, 0, C0, 0, 1, 0, 5);
    cyc(1, 0, 0, 0, 1, 0, 0, C0, 0, 1, 0, 5);
    cyc(1, 0, 0, 0, 1, 0, 0, C0, 0, 1, 0, 5);
    cyc(1, 0, 0, 0, 0, 0, 0, CI, 0, 1, 0, 5);
    cyc(1, 0, 0, 0, 1, 0, 0, CD, 0, 1, 0, 5);
    cyc(1, 0, 0, 0, 1, 0, 0, CE, 0, 1, 0, 5);
    cyc(1, 0, 0, 0, 1, 0, 0, C0, 0, 1, 0, 5);
    cyc(1, 0, 1, 0, 1, 0, 0, C0, 0, 1, 0, 5);
    cyc(1, 0, 0, 0, 0, 0, 0, CW, 0, 1, 0, 5);
    cyc(1, 0, 0, 0, 0, 0, 0, C0, 1, 0, 0, 6);

    // Reset asserted during EX.
    cyc(1, 1, 0, 0, 0, 0, 0, C0, 1, 0, 0, 6);
    cyc(1, 0, 0, 0, 0, 0, 0, CI, 0, 1, 0, 6);
    cyc(1, 0, 0, 0, 0, 0, 0, CD, 0, 1, 0, 6);
    cyc(0, 0, 0, 0, 0, 0, 0, C0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, C0, 1, 0, 0, 0);

    // cnt_clr coincident with WB completion.
    cyc(1, 1, 0, 0, 0, 0, 0, C0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, CI, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, CD, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0, 0, 0, CE, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 1, CW, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, C0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, C0, 1, 0, 0, 0);

    @(negedge clock);
    #1;
    tests_run++;
    if (exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
